// File: rtl/pool_engine.sv
// pool_engine: 2x2 stride-2 signed max pooling over CH independent feature maps.
// Reads each window from the conv-output RAM in four cycles and writes the pooled
// pixel to the pool-output RAM on the fifth cycle. One pixel is processed at a time.
module pool_engine #(
   parameter  int DW  = 16,
   parameter  int W   = 24,
   parameter  int H   = 24,
   parameter  int CH  = 4,
   localparam int AW  = (CH * H * W > 1) ? $clog2(CH * H * W) : 1,
   localparam int OAW = (CH * H * W / 4 > 1) ? $clog2(CH * H * W / 4) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 relu_en,
   output logic                 rd_en,
   output logic [AW-1:0]        rd_addr,
   input  logic signed [DW-1:0] rd_data,
   output logic                 wr_en,
   output logic [OAW-1:0]       wr_addr,
   output logic signed [DW-1:0] wr_data,
   output logic                 busy,
   output logic                 done
);

   // Counter widths, kept at least one bit wide for degenerate sizes.
   localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
   localparam int RW  = (H / 2 > 1) ? $clog2(H / 2) : 1;
   localparam int CW  = (W / 2 > 1) ? $clog2(W / 2) : 1;

   localparam logic [CHW-1:0] CH_LAST  = CHW'(CH - 1);
   localparam logic [RW-1:0]  ROW_LAST = RW'(H / 2 - 1);
   localparam logic [CW-1:0]  COL_LAST = CW'(W / 2 - 1);

   // Offsets from a window's top-left source address to its other three taps.
   localparam logic [AW-1:0] OFS_TR = AW'(1);
   localparam logic [AW-1:0] OFS_BL = AW'(W);
   localparam logic [AW-1:0] OFS_BR = AW'(W + 1);

   // Advancing the window: +2 along a row; +W+2 when the column wraps. Because the
   // maps are stored back to back, crossing into the next map is also +W+2.
   localparam logic [AW-1:0] STEP_COL = AW'(2);
   localparam logic [AW-1:0] STEP_ROW = AW'(W + 2);

   typedef enum logic [2:0] {
      IDLE,
      RD0,
      RD1,
      RD2,
      RD3,
      WR,
      DONE
   } state_t;

   state_t                 state_q;
   logic                   relu_q;
   logic [CHW-1:0]         ch_q;
   logic [RW-1:0]          orow_q;
   logic [CW-1:0]          ocol_q;
   logic [AW-1:0]          base_q;     // top-left source address of current window
   logic [OAW-1:0]         dst_q;      // destination index of current pixel
   logic signed [DW-1:0]   run_q;      // running window maximum
   logic                   rd_en_q;
   logic [AW-1:0]          rd_addr_q;
   logic                   wr_en_q;
   logic [OAW-1:0]         wr_addr_q;
   logic                   busy_q;
   logic                   done_q;

   logic                   col_wrap_d;
   logic                   row_wrap_d;
   logic                   last_pix_d;
   logic [AW-1:0]          base_d;
   logic signed [DW-1:0]   win_max_d;
   logic signed [DW-1:0]   wr_data_d;

   // Signed maximum by comparison only, so the most-negative value cannot overflow.
   // Ties return either operand, which are identical.
   function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                 input logic signed [DW-1:0] b);
      return (a > b) ? a : b;
   endfunction

   // Window bookkeeping and the write value, derived from current state.
   always_comb begin
      // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
      col_wrap_d = (ocol_q == COL_LAST);
      row_wrap_d = (orow_q == ROW_LAST);
      last_pix_d = col_wrap_d && row_wrap_d && (ch_q == CH_LAST);
      base_d     = base_q + (col_wrap_d ? STEP_ROW : STEP_COL);
      win_max_d  = smax(run_q, rd_data);
      wr_data_d  = '0;
      if (wr_en_q) begin
         wr_data_d = (relu_q && win_max_d[DW-1]) ? '0 : win_max_d;
      end
   end

   // Sequencer: walks the four taps of each window, writes the result, advances.
   // NOTE: sequential state uses non-blocking assignments so every register sees
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         relu_q    <= 1'b0;
         ch_q      <= '0;
         orow_q    <= '0;
         ocol_q    <= '0;
         base_q    <= '0;
         dst_q     <= '0;
         run_q     <= '0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         rd_en_q <= 1'b0;
         wr_en_q <= 1'b0;
         done_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  relu_q    <= relu_en;
                  ch_q      <= '0;
                  orow_q    <= '0;
                  ocol_q    <= '0;
                  base_q    <= '0;
                  dst_q     <= '0;
                  rd_en_q   <= 1'b1;
                  rd_addr_q <= '0;
                  busy_q    <= 1'b1;
                  state_q   <= RD0;
               end
            end
            RD0: begin
               rd_en_q   <= 1'b1;
               rd_addr_q <= base_q + OFS_TR;
               state_q   <= RD1;
            end
            RD1: begin
               run_q     <= rd_data;
               rd_en_q   <= 1'b1;
               rd_addr_q <= base_q + OFS_BL;
               state_q   <= RD2;
            end
            RD2: begin
               run_q     <= smax(run_q, rd_data);
               rd_en_q   <= 1'b1;
               rd_addr_q <= base_q + OFS_BR;
               state_q   <= RD3;
            end
            RD3: begin
               run_q     <= smax(run_q, rd_data);
               wr_en_q   <= 1'b1;
               wr_addr_q <= dst_q;
               state_q   <= WR;
            end
            WR: begin
               dst_q  <= dst_q + 1'b1;
               base_q <= base_d;
               if (col_wrap_d) begin
                  ocol_q <= '0;
                  if (row_wrap_d) begin
                     orow_q <= '0;
                     ch_q   <= ch_q + 1'b1;
                  end else begin
                     orow_q <= orow_q + 1'b1;
                  end
               end else begin
                  ocol_q <= ocol_q + 1'b1;
               end
               if (last_pix_d) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  rd_en_q   <= 1'b1;
                  rd_addr_q <= base_d;
                  state_q   <= RD0;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign rd_en   = rd_en_q;
   assign rd_addr = rd_addr_q;
   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_d;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_pool_engine.sv
// Testbench for pool_engine: a 4x4 single-map instance driven by a vector table
// and hand sequences, plus a default-size instance checked against a reference.
module tb_pool_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- small instance: W=H=4, CH=1 ----------------
   logic              rst_s, start_s, relu_s, rd_en_s, wr_en_s, busy_s, done_s;
   logic [3:0]        rd_addr_s;
   logic [1:0]        wr_addr_s;
   logic signed [15:0] rd_data_s, wr_data_s;
   logic signed [15:0] mem_s [16];

   pool_engine #(.DW(16), .W(4), .H(4), .CH(1)) u_small (
      .clk(clk), .reset(rst_s), .start(start_s), .relu_en(relu_s),
      .rd_en(rd_en_s), .rd_addr(rd_addr_s), .rd_data(rd_data_s),
      .wr_en(wr_en_s), .wr_addr(wr_addr_s), .wr_data(wr_data_s),
      .busy(busy_s), .done(done_s)
   );

   // ---------------- default instance: W=H=24, CH=4 ----------------
   logic              rst_d, start_d, relu_d, rd_en_d, wr_en_d, busy_d, done_d;
   logic [11:0]       rd_addr_d;
   logic [9:0]        wr_addr_d;
   logic signed [15:0] rd_data_d, wr_data_d;
   logic signed [15:0] mem_d [2304];
   logic signed [15:0] ref_d [576];

   pool_engine u_dflt (
      .clk(clk), .reset(rst_d), .start(start_d), .relu_en(relu_d),
      .rd_en(rd_en_d), .rd_addr(rd_addr_d), .rd_data(rd_data_d),
      .wr_en(wr_en_d), .wr_addr(wr_addr_d), .wr_data(wr_data_d),
      .busy(busy_d), .done(done_d)
   );

   // Source RAM models: data valid one cycle after the read strobe.
   always @(posedge clk) begin
      if (rd_en_s) rd_data_s <= mem_s[rd_addr_s];
      if (rd_en_d) rd_data_d <= mem_d[rd_addr_d];
   end

   // Monitors: write capture, done pulses, busy cycles, read/write overlap.
   int               cap_a_s[$];
   logic signed [15:0] cap_d_s[$];
   int               cap_a_d[$];
   logic signed [15:0] cap_d_d[$];
   int               done_cnt_s = 0;
   int               busy_cnt_d = 0;
   int               overlap    = 0;

   always @(negedge clk) begin
      if (wr_en_s) begin
         cap_a_s.push_back(int'(wr_addr_s));
         cap_d_s.push_back(wr_data_s);
      end
      if (wr_en_d) begin
         cap_a_d.push_back(int'(wr_addr_d));
         cap_d_d.push_back(wr_data_d);
      end
      if (done_s) done_cnt_s <= done_cnt_s + 1;
      if (busy_d) busy_cnt_d <= busy_cnt_d + 1;
      if ((rd_en_s && wr_en_s) || (rd_en_d && wr_en_d)) overlap <= overlap + 1;
   end

   // Vector table: one 2x2 window {TL, TR, BL, BR}, relu flag and expected output.
   typedef struct {
      logic signed [15:0] v [4];
      logic               relu;
      logic signed [15:0] exp;
   } vec_t;

   vec_t               tbl [8];
   logic signed [15:0] exp4 [4];

   task automatic set_vec(input int i, input int a, input int b, input int c, input int d,
                          input logic relu, input int e);
      tbl[i].v[0] = 16'(a);
      tbl[i].v[1] = 16'(b);
      tbl[i].v[2] = 16'(c);
      tbl[i].v[3] = 16'(d);
      tbl[i].relu = relu;
      tbl[i].exp  = 16'(e);
   endtask

   task automatic load_seq();
      for (int i = 0; i < 16; i++) mem_s[i] = 16'(i);
   endtask

   // Place table entries g*4..g*4+3 as the four output windows of the 4x4 map.
   task automatic load_group(input int g);
      for (int k = 0; k < 4; k++) begin
         int b;
         b = (k / 2) * 8 + (k % 2) * 2;
         mem_s[b]     = tbl[g*4+k].v[0];
         mem_s[b + 1] = tbl[g*4+k].v[1];
         mem_s[b + 4] = tbl[g*4+k].v[2];
         mem_s[b + 5] = tbl[g*4+k].v[3];
         exp4[k]      = tbl[g*4+k].exp;
      end
   endtask

   // Run the small instance to completion. relu_en is inverted after acceptance and
   // start optionally re-pulsed at cycle 'repulse' to show both are ignored mid-run.
   task automatic run_small(input string tag, input logic relu, input int repulse);
      int  t0;
      bit  seen;
      int  lat;
      cap_a_s.delete();
      cap_d_s.delete();
      @(negedge clk);
      start_s = 1'b1;
      relu_s  = relu;
      t0      = cyc;
      @(negedge clk);
      start_s = 1'b0;
      relu_s  = ~relu;
      check({tag, "_first_rd_en"}, rd_en_s, 1);
      check({tag, "_first_rd_addr"}, rd_addr_s, 0);
      seen = 1'b0;
      lat  = -1;
      for (int k = 2; k < 200 && !seen; k++) begin
         start_s = (k == repulse);
         @(negedge clk);
         if (done_s) begin
            seen = 1'b1;
            lat  = cyc - t0;
         end
      end
      start_s = 1'b0;
      check({tag, "_latency"}, lat, 21);
      check({tag, "_busy_at_done"}, busy_s, 0);
      @(negedge clk);
      check({tag, "_done_one_cycle"}, done_s, 0);
      check({tag, "_nwrites"}, cap_a_s.size(), 4);
      for (int i = 0; i < 4 && i < cap_a_s.size(); i++) begin
         check({tag, "_addr"}, cap_a_s[i], i);
         check({tag, "_data"}, cap_d_s[i], exp4[i]);
      end
   endtask

   initial begin
      int t0, lat, dc;
      bit seen;

      rst_s = 1'b0; start_s = 1'b0; relu_s = 1'b0;
      rst_d = 1'b0; start_d = 1'b0; relu_d = 1'b0;
      for (int i = 0; i < 16; i++) mem_s[i] = '0;

      // Vector table: group 0 with relu off, group 1 with relu on.
      set_vec(0,     -5,     -3,     -8,     -1, 1'b0,     -1);
      set_vec(1, -32768, -32768, -32768, -32768, 1'b0, -32768);
      set_vec(2,      7,      7,      7,      7, 1'b0,      7);
      set_vec(3,    100,   -200,  32767, -32768, 1'b0,  32767);
      set_vec(4,     -5,     -3,     -8,     -1, 1'b1,      0);
      set_vec(5,      3,     -4,      2,      1, 1'b1,      3);
      set_vec(6,     -9,      6,     -9,     -9, 1'b1,      6);
      set_vec(7,      0,     -1,     -2,      9, 1'b1,      9);

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_rd_en",   rd_en_s,   0);
      check("rst_wr_en",   wr_en_s,   0);
      check("rst_busy",    busy_s,    0);
      check("rst_done",    done_s,    0);
      check("rst_rd_addr", rd_addr_s, 0);
      check("rst_wr_addr", wr_addr_s, 0);
      check("rst_wr_data", wr_data_s, 0);
      rst_s = 1'b1;
      rst_d = 1'b1;
      repeat (2) @(negedge clk);

      // 4x4 map of 0..15.
      load_seq();
      exp4[0] = 5; exp4[1] = 7; exp4[2] = 13; exp4[3] = 15;
      run_small("seq", 1'b0, 0);

      // Table-driven windows.
      for (int g = 0; g < 2; g++) begin
         load_group(g);
         run_small($sformatf("tbl%0d", g), tbl[g*4].relu, 0);
      end

      // start re-pulsed at cycle 10 of the run.
      load_seq();
      exp4[0] = 5; exp4[1] = 7; exp4[2] = 13; exp4[3] = 15;
      run_small("repulse", 1'b0, 10);

      // Reset during RD2 of pixel 3 (window top-left 10, RD2 reads address 14).
      cap_a_s.delete();
      cap_d_s.delete();
      @(negedge clk);
      start_s = 1'b1;
      relu_s  = 1'b0;
      t0      = cyc;
      @(negedge clk);
      start_s = 1'b0;
      while (cyc - t0 < 18) @(negedge clk);
      check("mid_rd2_rd_en", rd_en_s, 1);
      check("mid_rd2_rd_addr", rd_addr_s, 14);
      #1;
      dc = done_cnt_s;
      rst_s = 1'b0;
      #1;
      check("mid_rst_rd_en", rd_en_s, 0);
      check("mid_rst_wr_en", wr_en_s, 0);
      check("mid_rst_busy",  busy_s,  0);
      repeat (3) @(negedge clk);
      rst_s = 1'b1;
      repeat (10) @(negedge clk);
      #1;
      check("mid_rst_no_done", done_cnt_s, dc);
      check("mid_rst_nwrites", cap_a_s.size(), 3);
      run_small("after_rst", 1'b0, 0);

      // Default-size instance with random data.
      for (int i = 0; i < 2304; i++) begin
         mem_d[i] = 16'($urandom);
         if ($urandom_range(0, 15) == 0) mem_d[i] = -16'sd32768;
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 12; r++)
            for (int q = 0; q < 12; q++) begin
               int b;
               logic signed [15:0] m;
               b = c * 576 + r * 48 + q * 2;
               m = mem_d[b];
               if (mem_d[b + 1]  > m) m = mem_d[b + 1];
               if (mem_d[b + 24] > m) m = mem_d[b + 24];
               if (mem_d[b + 25] > m) m = mem_d[b + 25];
               ref_d[c * 144 + r * 12 + q] = m;
            end
      cap_a_d.delete();
      cap_d_d.delete();
      @(negedge clk);
      #1;
      busy_cnt_d = 0;
      @(negedge clk);
      start_d = 1'b1;
      relu_d  = 1'b0;
      t0      = cyc;
      @(negedge clk);
      start_d = 1'b0;
      seen = 1'b0;
      lat  = -1;
      for (int k = 2; k < 4000 && !seen; k++) begin
         @(negedge clk);
         if (done_d) begin
            seen = 1'b1;
            lat  = cyc - t0;
         end
      end
      #1;
      check("dflt_latency", lat, 2881);
      check("dflt_busy_cycles", busy_cnt_d, 2880);
      check("dflt_nwrites", cap_a_d.size(), 576);
      for (int i = 0; i < 576 && i < cap_a_d.size(); i++) begin
         check($sformatf("dflt_addr%0d", i), cap_a_d[i], i);
         check($sformatf("dflt_data%0d", i), cap_d_d[i], ref_d[i]);
      end

      check("rd_wr_overlap", overlap, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
